frame_seq_gen: RTL and testbench
================================

// Module: frame_seq_gen
// PURPOSE
//  Parametrised multi-channel DAC frame sequencer; next generation of the CLIO frame state block.
//  Pulls words from the upstream sample FIFO and serialises them MSB-first on NUM_CH parallel data lanes.
//  Generates the shared CCLK and the FRAME strobe for reg_delay frames of reg_length words each.
//  Supports one-shot and loop modes, a programmable inter-frame gap and underrun detection.
//  Sits between the host-loaded sample FIFO and the DAC pins.
// PARAMETERS
//  DATA_W    8   bits per word per channel
//  NUM_CH    2   parallel serial lanes; fifo_dout packs channel 0 in the LSBs
//  CNT_W     32  width of the length, delay, gap and FIFO-count registers
//  CCLK_DIV  2   ti_clk cycles per CCLK half-period; minimum 2
// PORTS
//  ti_clk           in   1               system clock; all logic is on its rising edge
//  rst              in   1               synchronous, active-high reset
//  start            in   1               1-cycle pulse; sampled only in IDLE
//  abort            in   1               synchronous abort; return to IDLE
//  loop_mode        in   1               1 = restart after the last frame, 0 = one-shot
//  reg_length       in   CNT_W           words per frame
//  reg_delay        in   CNT_W           frames (columns) per run
//  reg_gap          in   CNT_W           idle ti_clk cycles between frames
//  read_byte_count  in   CNT_W           upstream FIFO fill level, in words
//  fifo_dout        in   DATA_W*NUM_CH   FIFO data; valid 1 cycle after frame_rd_en
//  frame_rd_en      out  1               FIFO read strobe; 1-cycle pulse per word
//  FRAME            out  1               high while a frame is shifting
//  CCLK             out  1               DAC serial clock; idles low
//  SDATA            out  NUM_CH          serial data lanes; change on CCLK fall
//  dac_ready        out  1               high in IDLE only
//  busy             out  1               = ~dac_ready
//  underrun         out  1               sticky; cleared by rst or by an accepted start
// BEHAVIOUR
//  - Reset and abort: state IDLE; dac_ready=1; all other outputs 0; counters 0.
//    Abort takes effect on the next edge and has priority over every other event. rst has priority over abort.
//  - Start handling: start in IDLE latches reg_length, reg_delay, reg_gap and loop_mode into shadow registers.
//    Register changes during a run are ignored.
//    start is ignored if the latched length or delay would be 0.
//  - States: IDLE -> WAIT_DATA -> PRIME -> SHIFT -> (GAP -> WAIT_DATA | DONE) ; DONE -> IDLE.
//  - WAIT_DATA: hold until read_byte_count >= shadow length, then pulse frame_rd_en and go to PRIME.
//  - PRIME (1 cycle): load the shift registers from fifo_dout.
//    Next cycle enters SHIFT with FRAME=1 and SDATA = bit DATA_W-1 of each lane.
//  - SHIFT: CCLK toggles every CCLK_DIV cycles; bit period = 2*CCLK_DIV cycles.
//    CCLK rises mid-bit; SDATA updates on the ti_clk edge that drops CCLK.
//  - Next-word prefetch: during the last bit of a non-final word, frame_rd_en pulses in the first cycle of that bit.
//    fifo_dout is captured into a holding register the next cycle and loaded at the word boundary.
//    Words are back-to-back with no CCLK gap.
//  - Underrun: if read_byte_count==0 when a mid-frame read is due, no read is issued.
//    That word shifts all zeros and underrun latches 1. The frame continues.
//  - End of frame: after the last bit of the last word, FRAME and CCLK drop on the same edge.
//    If frames remain, go to GAP for shadow gap cycles (0 = straight to WAIT_DATA).
//    Otherwise go to DONE (1 cycle). In loop mode, go to GAP/WAIT_DATA and reload the frame counter.
//  - Counters are CNT_W wide and never wrap. The frame counter compares down to 0.
// CONFIGURATION
//  FRAME_SEQ_PARITY_EN defined:
//    - each word is followed by one extra bit per lane: even parity of that lane's DATA_W bits.
//    - word length becomes DATA_W+1 bit periods. Prefetch moves to the parity bit.
//  FRAME_SEQ_PARITY_EN undefined:
//    - no parity bit. Word = exactly DATA_W bit periods.
// TESTING
//  (defaults, NUM_CH=1, CCLK_DIV=2, parity off)
//  1. rst=1 for 2 cycles -> dac_ready=1, FRAME=CCLK=SDATA=frame_rd_en=underrun=0.
//  2. len=6, delay=3, gap=0, count=18, start -> 3 frames of 192 cycles each.
//     CCLK period 4 cycles; 18 frame_rd_en pulses total; then DONE, then dac_ready=1.
//  3. len=2, word 0xA5 -> SDATA sequence 1,0,1,0,0,1,0,1.
//     CCLK rises 2 cycles after each SDATA change.
//  4. len=6, count=3 at start -> stays in WAIT_DATA with no rd_en until count=6.
//     Drop count to 0 mid-frame -> zero word shifted, underrun=1 until the next start.
//  5. loop_mode=1, gap=10 -> FRAME low for exactly 10 cycles plus WAIT_DATA/PRIME between frames.
//     Runs indefinitely; abort mid-word -> IDLE and all outputs 0 on the next edge.
//  6. With FRAME_SEQ_PARITY_EN, word 0x07 -> 9 bits, parity bit 1; frame length 216 cycles for len=6.

Source files
------------

// File: rtl/frame_seq_gen.sv
// Multi-channel DAC frame sequencer: pulls FIFO words and shifts them MSB-first on NUM_CH lanes with CCLK/FRAME.
// Optional per-word even-parity bit when FRAME_SEQ_PARITY_EN is defined.
module frame_seq_gen #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned CCLK_DIV = 2
) (
  input  logic                     ti_clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     loop_mode,
  input  logic [CNT_W-1:0]         reg_length,
  input  logic [CNT_W-1:0]         reg_delay,
  input  logic [CNT_W-1:0]         reg_gap,
  input  logic [CNT_W-1:0]         read_byte_count,
  input  logic [DATA_W*NUM_CH-1:0] fifo_dout,
  output logic                     frame_rd_en,
  output logic                     FRAME,
  output logic                     CCLK,
  output logic [NUM_CH-1:0]        SDATA,
  output logic                     dac_ready,
  output logic                     busy,
  output logic                     underrun
);

`ifdef FRAME_SEQ_PARITY_EN
  localparam int unsigned NBITS = DATA_W + 1;
`else
  localparam int unsigned NBITS = DATA_W;
`endif
  localparam int unsigned BIT_W  = $clog2(NBITS + 1);
  localparam int unsigned DIV_W  = $clog2(2 * CCLK_DIV + 1);
  localparam int unsigned WORD_W = DATA_W * NUM_CH;
  localparam int unsigned SREG_W = NBITS * NUM_CH;

  typedef enum logic [2:0] {IDLE, WAIT_DATA, PRIME, SHIFT, GAP, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   sh_len, sh_delay, sh_gap;
  logic               sh_loop;
  logic [CNT_W-1:0]   frame_cnt, words_left, gap_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_idx;
  logic [SREG_W-1:0]  sreg;
  logic [WORD_W-1:0]  hold;
  logic               cap_pend;

  logic               accept_c, fetch_c, phase_mid_c, phase_last_c, bit_last_c;
  logic               word_last_c, frame_end_c, more_c, prefetch_c, starve_c;
  logic [WORD_W-1:0]  load_src_c;
  logic [SREG_W-1:0]  load_lanes_c, shl_c;

  // State register
  always_ff @(posedge ti_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept_c) state_nxt = WAIT_DATA;
      WAIT_DATA: if (frame_rd_en) state_nxt = PRIME;
      PRIME:     state_nxt = SHIFT;
      SHIFT:     if (frame_end_c)
                   state_nxt = !more_c ? DONE : ((sh_gap != '0) ? GAP : WAIT_DATA);
      GAP:       if (gap_cnt <= CNT_W'(1)) state_nxt = WAIT_DATA;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Control decode
  always_comb begin
    accept_c     = (state == IDLE) && start && (reg_length != '0) && (reg_delay != '0);
    fetch_c      = (state == WAIT_DATA) && !frame_rd_en && (read_byte_count >= sh_len);
    phase_mid_c  = (div_cnt == DIV_W'(CCLK_DIV - 1));
    phase_last_c = (div_cnt == DIV_W'(2 * CCLK_DIV - 1));
    bit_last_c   = (bit_idx == BIT_W'(NBITS - 1));
    word_last_c  = (words_left == CNT_W'(1));
    frame_end_c  = (state == SHIFT) && phase_last_c && bit_last_c && word_last_c;
    more_c       = sh_loop || (frame_cnt > CNT_W'(1));
    prefetch_c   = (state == SHIFT) && phase_last_c && !word_last_c &&
                   (bit_idx == BIT_W'(NBITS - 2));
    starve_c     = (read_byte_count == '0);
  end

  // Lane packing: each lane holds its word (plus parity) with the next bit to send at the top
  always_comb begin
    load_src_c   = (state == PRIME) ? fifo_dout : hold;
    load_lanes_c = '0;
    shl_c        = '0;
    SDATA        = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
`ifdef FRAME_SEQ_PARITY_EN
      load_lanes_c[ch*NBITS +: NBITS] = {load_src_c[ch*DATA_W +: DATA_W],
                                         ^load_src_c[ch*DATA_W +: DATA_W]};
`else
      load_lanes_c[ch*NBITS +: NBITS] = load_src_c[ch*DATA_W +: DATA_W];
`endif
      shl_c[ch*NBITS +: NBITS] = {sreg[ch*NBITS +: NBITS-1], 1'b0};
      SDATA[ch] = sreg[ch*NBITS + NBITS - 1];
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge ti_clk) begin
    if (rst || abort) begin
      dac_ready   <= 1'b1;
      busy        <= 1'b0;
      frame_rd_en <= 1'b0;
      FRAME       <= 1'b0;
      CCLK        <= 1'b0;
      underrun    <= 1'b0;
      sh_len      <= '0;
      sh_delay    <= '0;
      sh_gap      <= '0;
      sh_loop     <= 1'b0;
      frame_cnt   <= '0;
      words_left  <= '0;
      gap_cnt     <= '0;
      div_cnt     <= '0;
      bit_idx     <= '0;
      sreg        <= '0;
      hold        <= '0;
      cap_pend    <= 1'b0;
    end else begin
      dac_ready   <= (state_nxt == IDLE);
      busy        <= (state_nxt != IDLE);
      frame_rd_en <= fetch_c || (prefetch_c && !starve_c);
      cap_pend    <= frame_rd_en && (state == SHIFT);
      if (cap_pend) hold <= fifo_dout;
      // Starved prefetch: skip the read and send a zero word
      if (prefetch_c && starve_c) begin
        hold     <= '0;
        underrun <= 1'b1;
      end
      if (accept_c) begin
        sh_len    <= reg_length;
        sh_delay  <= reg_delay;
        sh_gap    <= reg_gap;
        sh_loop   <= loop_mode;
        frame_cnt <= reg_delay;
        underrun  <= 1'b0;
      end
      case (state)
        PRIME: begin
          sreg       <= load_lanes_c;
          FRAME      <= 1'b1;
          div_cnt    <= '0;
          bit_idx    <= '0;
          words_left <= sh_len;
        end
        SHIFT: begin
          div_cnt <= phase_last_c ? '0 : div_cnt + DIV_W'(1);
          if (phase_mid_c) CCLK <= 1'b1;
          if (phase_last_c) begin
            CCLK <= 1'b0;
            if (!bit_last_c) begin
              sreg    <= shl_c;
              bit_idx <= bit_idx + BIT_W'(1);
            end else if (!word_last_c) begin
              sreg       <= load_lanes_c;
              bit_idx    <= '0;
              words_left <= words_left - CNT_W'(1);
            end else begin
              sreg    <= '0;
              bit_idx <= '0;
              FRAME   <= 1'b0;
              gap_cnt <= sh_gap;
              if (frame_cnt > CNT_W'(1)) frame_cnt <= frame_cnt - CNT_W'(1);
              else if (sh_loop)          frame_cnt <= sh_delay;
              else if (frame_cnt != '0)  frame_cnt <= frame_cnt - CNT_W'(1);
            end
          end
        end
        GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_seq_gen.sv
// Directed bench for frame_seq_gen (NUM_CH=1, DATA_W=8, CCLK_DIV=2) with a small FIFO responder.
// Expected values follow the parity option when FRAME_SEQ_PARITY_EN is defined.
module tb_frame_seq_gen;

`ifdef FRAME_SEQ_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int FLEN6 = 6 * NB * 4;
  localparam int BUSY2 = 3 * (FLEN6 + 3) + 1;

  logic        ti_clk = 1'b0;
  logic        rst, start, abort, loop_mode;
  logic [31:0] reg_length, reg_delay, reg_gap, read_byte_count;
  logic [7:0]  fifo_dout;
  logic        frame_rd_en, FRAME, CCLK, dac_ready, busy, underrun;
  logic [0:0]  SDATA;

  frame_seq_gen #(.DATA_W(8), .NUM_CH(1), .CNT_W(32), .CCLK_DIV(2)) dut (
    .ti_clk(ti_clk), .rst(rst), .start(start), .abort(abort), .loop_mode(loop_mode),
    .reg_length(reg_length), .reg_delay(reg_delay), .reg_gap(reg_gap),
    .read_byte_count(read_byte_count), .fifo_dout(fifo_dout),
    .frame_rd_en(frame_rd_en), .FRAME(FRAME), .CCLK(CCLK), .SDATA(SDATA),
    .dac_ready(dac_ready), .busy(busy), .underrun(underrun)
  );

  always #5 ti_clk = ~ti_clk;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] fifo_mem [0:63];
  int rd_ptr, cyc, rd_cnt, frame_cyc, busy_cyc, frame_rises, nbits, ones;
  int cur_run, last_run, low_run, last_low, frame_rise_cyc, cclk_lag;
  logic rd_pend, prev_frame, prev_cclk, cclk_seen;
  logic [63:0] bits;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    rd_cnt = 0; frame_cyc = 0; busy_cyc = 0; frame_rises = 0; nbits = 0; ones = 0;
    cur_run = 0; last_run = 0; low_run = 0; last_low = 0; cclk_seen = 1'b0; cclk_lag = -1;
    bits = '0; rd_ptr = 0;
  endtask

  // One clock: FIFO answers a strobe after the edge, then outputs are sampled on the falling edge
  task automatic tick();
    @(posedge ti_clk);
    #1;
    if (rd_pend) begin
      fifo_dout = fifo_mem[rd_ptr % 64];
      rd_ptr++;
    end
    @(negedge ti_clk);
    cyc++;
    rd_pend = frame_rd_en;
    if (frame_rd_en) rd_cnt++;
    if (busy) busy_cyc++;
    if (FRAME) begin
      if (!prev_frame) begin
        frame_rises++; last_low = low_run; cur_run = 0; frame_rise_cyc = cyc;
      end
      cur_run++; frame_cyc++;
    end else begin
      if (prev_frame) begin last_run = cur_run; low_run = 0; end
      low_run++;
    end
    if (CCLK && !prev_cclk) begin
      bits = {bits[62:0], SDATA[0]};
      nbits++;
      if (SDATA[0]) ones++;
      if (!cclk_seen) begin cclk_seen = 1'b1; cclk_lag = cyc - frame_rise_cyc; end
    end
    prev_frame = FRAME;
    prev_cclk  = CCLK;
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int n = 0;
    while (dac_ready !== 1'b1 && n < budget) begin tick(); n++; end
    check(tag, 64'(dac_ready), 64'd1);
  endtask

  task automatic wait_frame(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (FRAME !== lvl && n < budget) begin tick(); n++; end
    check(tag, 64'(FRAME), 64'(lvl));
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; loop_mode = 1'b0;
    reg_length = 0; reg_delay = 0; reg_gap = 0; read_byte_count = 0; fifo_dout = 8'h00;
    rd_pend = 1'b0; prev_frame = 1'b0; prev_cclk = 1'b0; cyc = 0; frame_rise_cyc = 0;
    for (int i = 0; i < 64; i++) fifo_mem[i] = 8'(i * 37 + 5);
    clear_stats();

    // Reset state
    tick(); tick();
    check("rst_dac_ready", 64'(dac_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame", 64'(FRAME), 64'd0);
    check("rst_cclk", 64'(CCLK), 64'd0);
    check("rst_sdata", 64'(SDATA), 64'd0);
    check("rst_rd_en", 64'(frame_rd_en), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    rst = 1'b0;
    tick();

    // Three one-shot frames of six words
    reg_length = 6; reg_delay = 3; reg_gap = 0; read_byte_count = 18;
    clear_stats();
    pulse_start();
    wait_ready(2000, "t2_done");
    check("t2_busy_cycles", 64'(busy_cyc), 64'(BUSY2));
    check("t2_frames", 64'(frame_rises), 64'd3);
    check("t2_frame_len", 64'(last_run), 64'(FLEN6));
    check("t2_frame_total", 64'(frame_cyc), 64'(3 * FLEN6));
    check("t2_rd_pulses", 64'(rd_cnt), 64'd18);
    check("t2_cclk_rises", 64'(nbits), 64'(3 * 6 * NB));
    check("t2_underrun", 64'(underrun), 64'd0);

    // Bit order across a two-word frame
    fifo_mem[0] = 8'hA5; fifo_mem[1] = 8'h3C;
    reg_length = 2; reg_delay = 1;
    clear_stats();
    pulse_start();
    wait_ready(400, "t3_done");
    check("t3_nbits", 64'(nbits), 64'(2 * NB));
`ifdef FRAME_SEQ_PARITY_EN
    check("t3_bits", bits, 64'({8'hA5, 1'b0, 8'h3C, 1'b0}));
`else
    check("t3_bits", bits, 64'h0000_0000_0000_A53C);
`endif
    check("t3_cclk_lag", 64'(cclk_lag), 64'd2);
    check("t3_rd_pulses", 64'(rd_cnt), 64'd2);

    // Waits for the FIFO level, then starves mid-frame
    fifo_mem[0] = 8'hFF;
    reg_length = 6; reg_delay = 1; read_byte_count = 3;
    clear_stats();
    pulse_start();
    repeat (20) tick();
    check("t4_no_rd_while_low", 64'(rd_cnt), 64'd0);
    check("t4_still_busy", 64'(busy), 64'd1);
    check("t4_no_frame", 64'(FRAME), 64'd0);
    read_byte_count = 6;
    wait_frame(1'b1, 10, "t4_frame_start");
    repeat (10) tick();
    read_byte_count = 0;
    wait_ready(600, "t4_done");
    check("t4_rd_pulses", 64'(rd_cnt), 64'd1);
    check("t4_ones", 64'(ones), 64'd8);
    check("t4_nbits", 64'(nbits), 64'(6 * NB));
    check("t4_underrun", 64'(underrun), 64'd1);
    reg_length = 0;
    pulse_start();
    check("t4_zero_len_ignored", 64'(dac_ready), 64'd1);
    check("t4_underrun_kept", 64'(underrun), 64'd1);
    reg_length = 1; read_byte_count = 6;
    pulse_start();
    check("t4_underrun_cleared", 64'(underrun), 64'd0);
    check("t4_restart_busy", 64'(busy), 64'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t4_abort_idle", 64'(dac_ready), 64'd1);

    // Loop mode with a ten-cycle gap, then abort mid-word
    for (int i = 0; i < 64; i++) fifo_mem[i] = 8'hFF;
    reg_length = 1; reg_delay = 1; reg_gap = 10; loop_mode = 1'b1; read_byte_count = 6;
    clear_stats();
    pulse_start();
    loop_mode = 1'b0;
    wait_frame(1'b1, 20, "t5_f1_rise");
    wait_frame(1'b0, 60, "t5_f1_fall");
    wait_frame(1'b1, 60, "t5_f2_rise");
    check("t5_gap_low", 64'(last_low), 64'd13);
    wait_frame(1'b0, 60, "t5_f2_fall");
    check("t5_frame_len", 64'(last_run), 64'(NB * 4));
    wait_frame(1'b1, 60, "t5_f3_rise");
    check("t5_looping", 64'(frame_rises), 64'd3);
    repeat (5) tick();
    check("t5_mid_word_sdata", 64'(SDATA), 64'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t5_abort_ready", 64'(dac_ready), 64'd1);
    check("t5_abort_busy", 64'(busy), 64'd0);
    check("t5_abort_frame", 64'(FRAME), 64'd0);
    check("t5_abort_cclk", 64'(CCLK), 64'd0);
    check("t5_abort_sdata", 64'(SDATA), 64'd0);
    check("t5_abort_rd_en", 64'(frame_rd_en), 64'd0);
    repeat (3) tick();
    check("t5_stays_idle", 64'(dac_ready), 64'd1);

`ifdef FRAME_SEQ_PARITY_EN
    // Parity bit after each word
    for (int i = 0; i < 64; i++) fifo_mem[i] = 8'h07;
    reg_length = 6; reg_delay = 1; reg_gap = 0; read_byte_count = 18;
    clear_stats();
    pulse_start();
    wait_ready(600, "t6_done");
    check("t6_first_word", 64'(bits[53:45]), 64'h00F);
    check("t6_frame_len", 64'(last_run), 64'd216);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
